// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port (optional fairness: ARB_FAIRNESS_EN)
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  stall_f
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arbStateT;

  arbStateT arbState;
  logic     grantDm;
  logic     grantIf;

`ifdef ARB_FAIRNESS_EN
  localparam int StreakW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);

  logic [StreakW-1:0] dmStreak;

  // Fetch takes its turn once data has won MAX_DM_STREAK times in a row over it
  assign grantDm = dm_req && !(if_req && (dmStreak == StreakW'(MAX_DM_STREAK)));
`else
  // Data port has strict priority over fetch
  assign grantDm = dm_req;
`endif

  assign grantIf = if_req && !grantDm;

  // Fetch stalls for as long as its request is open and not yet answered
  assign stall_f = if_req && !if_ready;

  // Arbitration FSM: grant from IDLE, wait for mem_valid in BUSY, pulse ready on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      arbState  <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef ARB_FAIRNESS_EN
      dmStreak  <= '0;
`endif
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (arbState)
        IDLE: begin
          if (grantDm) begin
            arbState  <= DM_BUSY;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
`ifdef ARB_FAIRNESS_EN
            dmStreak  <= if_req ? dmStreak + StreakW'(1) : '0;
`endif
          end else if (grantIf) begin
            arbState  <= IF_BUSY;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
`ifdef ARB_FAIRNESS_EN
            dmStreak  <= '0;
`endif
          end
        end
        IF_BUSY: begin
          if (mem_valid) begin
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
            arbState <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_valid) begin
            // mem_we still holds the granted direction; a store leaves dm_rdata alone
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_ready <= 1'b1;
            arbState <= IDLE;
          end
        end
        default: arbState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (model + directed vectors)
module tb_mem_arbiter;

  localparam int DW         = 32;
  localparam int MAX_STREAK = 4;
`ifdef ARB_FAIRNESS_EN
  localparam int EXP_DM_BEFORE_IF = 4;
`else
  localparam int EXP_DM_BEFORE_IF = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ready, dm_req, dm_we, dm_ready;
  logic [DW-1:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic          mem_en, mem_we, mem_valid, stall_f;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_DM_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall_f(stall_f)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] initWord(input logic [DW-1:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  // ---------------- memory device: mem_valid arrives memLat-1 cycles after the mem_en cycle
  logic [DW-1:0] devMem [logic [DW-1:0]];
  int            memLat = 2;
  bit            strayValid = 0;
  bit            pendActive = 0;
  int            pendCnt;
  logic [DW-1:0] pendAddr, pendWdata;
  logic          pendWe;

  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (mem_en === 1'b1) begin
        pendActive = 1;
        pendCnt    = memLat - 1;
        pendAddr   = mem_addr;
        pendWe     = mem_we;
        pendWdata  = mem_wdata;
      end
      if (pendActive) begin
        if (pendCnt == 0) begin
          mem_valid = 1'b1;
          if (pendWe) begin
            devMem[pendAddr] = pendWdata;
            mem_rdata = 32'hFFFFFFFF;
          end else begin
            mem_rdata = devMem.exists(pendAddr) ? devMem[pendAddr] : initWord(pendAddr);
          end
          pendActive = 0;
        end else begin
          pendCnt--;
        end
      end
      if (strayValid) begin
        mem_valid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // ---------------- behavioural model: who owns the memory, what the next cycle must show
  logic [DW-1:0] refMem [logic [DW-1:0]];
  int            owner = 0;     // 0 nobody, 1 fetch, 2 data
  int            dmWins = 0;    // data wins in a row while fetch waits
  bit            modelValid = 0;
  bit            fetchTurn;
  logic [DW-1:0] accAddr, accWdata;
  logic          accWe;
  logic          expEn, expWe, expIfReady, expDmReady;
  logic [DW-1:0] expAddr, expWdata, expIfRdata, expDmRdata;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      owner = 0; dmWins = 0; modelValid = 1;
      expEn = 0; expWe = 0; expIfReady = 0; expDmReady = 0;
      expAddr = 0; expWdata = 0; expIfRdata = 0; expDmRdata = 0;
    end else if (modelValid) begin
      expEn = 0; expIfReady = 0; expDmReady = 0;
      if (owner == 0) begin
        fetchTurn = 0;
`ifdef ARB_FAIRNESS_EN
        fetchTurn = if_req && (dmWins >= MAX_STREAK);
`endif
        if (dm_req && !fetchTurn) begin
          owner = 2; accAddr = dm_addr; accWe = dm_we; accWdata = dm_wdata;
          dmWins = if_req ? dmWins + 1 : 0;
          expEn = 1; expWe = dm_we; expAddr = dm_addr; expWdata = dm_wdata;
        end else if (if_req) begin
          owner = 1; accAddr = if_addr; accWe = 0; accWdata = 0;
          dmWins = 0;
          expEn = 1; expWe = 0; expAddr = if_addr; expWdata = 0;
        end
      end else if (mem_valid) begin
        if (owner == 1) begin
          expIfReady = 1;
          expIfRdata = refMem.exists(accAddr) ? refMem[accAddr] : initWord(accAddr);
        end else begin
          expDmReady = 1;
          if (accWe) refMem[accAddr] = accWdata;
          else expDmRdata = refMem.exists(accAddr) ? refMem[accAddr] : initWord(accAddr);
        end
        owner = 0;
      end
    end
  end

  // ---------------- compare process and memory-command log
  typedef struct {
    int            cyc;
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } enRecord;

  enRecord enLog[$];
  int      cycle = 0;

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (modelValid) begin
        check("mem_en", {31'b0, mem_en}, {31'b0, expEn});
        check("mem_we", {31'b0, mem_we}, {31'b0, expWe});
        check("mem_addr", mem_addr, expAddr);
        check("mem_wdata", mem_wdata, expWdata);
        check("if_ready", {31'b0, if_ready}, {31'b0, expIfReady});
        check("dm_ready", {31'b0, dm_ready}, {31'b0, expDmReady});
        check("if_rdata", if_rdata, expIfRdata);
        check("dm_rdata", dm_rdata, expDmRdata);
        check("stall_f", {31'b0, stall_f}, {31'b0, (if_req && !expIfReady)});
      end
      if (mem_en === 1'b1) enLog.push_back('{cycle, mem_addr, mem_we, mem_wdata});
    end
  end

  // ---------------- stimulus helpers (inputs change 1 time unit after the rising edge)
  task automatic waitReady(input bit isDm, input int maxCycles, input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    while (!seen && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
      seen = isDm ? dm_ready : if_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no ready pulse within %0d cycles", name, maxCycles);
    end
  endtask

  task automatic dmAccess(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    waitReady(1, 40, "dm_timeout");
    dm_req = 0;
  endtask

  task automatic fetch(input logic [DW-1:0] addr, input int maxCycles);
    if_req = 1; if_addr = addr;
    waitReady(0, maxCycles, "if_timeout");
    if_req = 0;
  endtask

  int dmBeforeIf;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);

    // fetch only, latency 2
    memLat = 2; enLog.delete();
    if_req = 1; if_addr = 32'h10;
    waitReady(0, 40, "fetch_timeout");
    check("fetch_if_rdata", if_rdata, 32'hC0DE0010);
    check("fetch_stall_low", {31'b0, stall_f}, 32'h0);
    check("fetch_en_count", 32'(enLog.size()), 32'd1);
    if_req = 0;
    @(posedge clk); #1;

    // simultaneous requests, latency 3: data first, fetch latency+1 later
    memLat = 3; enLog.delete();
    fork
      fetch(32'h40, 40);
      dmAccess(0, 32'h100, 0);
    join
    check("simul_en_count", 32'(enLog.size()), 32'd2);
    if (enLog.size() >= 2) begin
      check("simul_first_addr", enLog[0].addr, 32'h100);
      check("simul_second_addr", enLog[1].addr, 32'h40);
      check("simul_spacing", 32'(enLog[1].cyc - enLog[0].cyc), 32'd4);
    end
    check("simul_dm_rdata", dm_rdata, 32'hC0DE0100);
    check("simul_if_rdata", if_rdata, 32'hC0DE0040);

    // store, then read it back
    memLat = 2; enLog.delete();
    dmAccess(1, 32'h20, 32'hDEADBEEF);
    check("store_rdata_kept", dm_rdata, 32'hC0DE0100);
    if (enLog.size() >= 1) begin
      check("store_we", {31'b0, enLog[0].we}, 32'd1);
      check("store_addr", enLog[0].addr, 32'h20);
      check("store_wdata", enLog[0].wdata, 32'hDEADBEEF);
    end
    dmAccess(0, 32'h20, 0);
    check("store_readback", dm_rdata, 32'hDEADBEEF);

    // starvation: 10 back-to-back data loads against a waiting fetch, latency 1
    memLat = 1; enLog.delete();
    fork
      fetch(32'h80, 100);
      begin
        dm_req = 1; dm_we = 0;
        for (int i = 0; i < 10; i++) begin
          dm_addr = 32'h200 + 32'(4 * i);
          waitReady(1, 60, "starve_dm_timeout");
        end
        dm_req = 0;
      end
    join
    dmBeforeIf = -1;
    for (int i = 0; i < enLog.size(); i++) begin
      if (dmBeforeIf < 0 && enLog[i].addr == 32'h80) dmBeforeIf = i;
    end
    check("starve_dm_before_if", 32'(dmBeforeIf), 32'(EXP_DM_BEFORE_IF));
    check("starve_total_grants", 32'(enLog.size()), 32'd11);

    // stray mem_valid while idle
    @(posedge clk); #1 strayValid = 1;
    @(posedge clk); #1 strayValid = 0;
    check("stray_dm_ready", {31'b0, dm_ready}, 32'h0);
    check("stray_if_ready", {31'b0, if_ready}, 32'h0);

    // data request dropped after grant still completes; fetch dropped before grant is lost
    memLat = 4; enLog.delete();
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    @(posedge clk); #1;
    dm_req = 0; if_req = 1; if_addr = 32'h99;
    @(posedge clk); #1 if_req = 0;
    waitReady(1, 20, "drop_dm_timeout");
    check("drop_dm_rdata", dm_rdata, 32'hC0DE0060);
    repeat (3) @(posedge clk); #1;
    check("drop_no_fetch_grant", 32'(enLog.size()), 32'd1);

    // reset in the middle of a data access, late mem_valid discarded
    memLat = 4;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    @(posedge clk); #1 dm_req = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk); #1;
    check("rstmid_dm_ready", {31'b0, dm_ready}, 32'h0);
    check("rstmid_mem_en", {31'b0, mem_en}, 32'h0);
    check("rstmid_mem_we", {31'b0, mem_we}, 32'h0);
    check("rstmid_mem_addr", mem_addr, 32'h0);
    check("rstmid_mem_wdata", mem_wdata, 32'h0);
    check("rstmid_if_rdata", if_rdata, 32'h0);
    check("rstmid_dm_rdata", dm_rdata, 32'h0);
    memLat = 2;
    dmAccess(0, 32'h44, 0);
    check("rstmid_next_load", dm_rdata, 32'hC0DE0044);

    repeat (3) @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
